mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 4:1 single-bit multiplexer among four requesters.
- Each requester raises a request; the arbiter grants one at a time and drives the mux select (s1,s0) to route that requester's data bit to y.
- A hold limit guarantees fairness.
- Sits in front of the four_one_mux datapath and owns its select lines.

---
 rtl/mux4_rr_arbiter.sv | 117 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select lines of a shared 4:1 single-bit mux.
// Grants one requester at a time, with a hold limit so that every pending requester is eventually served.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       I0,
    input  logic       I1,
    input  logic       I2,
    input  logic       I3,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       y,
    output logic       y_valid,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] gnt_q, gnt_d;
    logic [3:0] others;
    logic [3:0] data;

    // First set bit of r, searching upward from base and wrapping 3->0.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        logic       found;
        pick  = base;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = base + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        others  = req & ~gnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    sel_d   = pick(req, ptr_q);
                    gnt_d   = 4'b0001 << sel_d;
                    hold_d  = 4'd1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    ptr_d = sel_q + 2'd1;
                    if (|others) begin
                        sel_d  = pick(others, sel_q + 2'd1);
                        gnt_d  = 4'b0001 << sel_d;
                        hold_d = 4'd1;
                    end else begin
                        // Select is left at the last owner while idle.
                        gnt_d   = '0;
                        hold_d  = '0;
                        state_d = IDLE;
                    end
                end else if (hold_q == MAX_HOLD_C && |others) begin
                    ptr_d  = sel_q + 2'd1;
                    sel_d  = pick(others, sel_q + 2'd1);
                    gnt_d  = 4'b0001 << sel_d;
                    hold_d = 4'd1;
                end else if (hold_q != MAX_HOLD_C) begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
        end
    end

    assign data    = {I3, I2, I1, I0};
    assign gnt     = gnt_q;
    assign s1      = sel_q[1];
    assign s0      = sel_q[0];
    assign y_valid = |gnt_q;
    assign y       = y_valid & data[sel_q];
    assign busy    = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an integer-level arbitration model.
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] data;
    logic [3:0] gnt;
    logic       s1, s0, y, y_valid, busy;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: owner = -1 when idle.
    int  m_owner = -1;
    int  m_ptr   = 0;
    int  m_hold  = 0;
    int  m_sel   = 0;
    bit  m_valid = 0;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .I0     (data[0]),
        .I1     (data[1]),
        .I2     (data[2]),
        .I3     (data[3]),
        .gnt    (gnt),
        .s1     (s1),
        .s0     (s0),
        .y      (y),
        .y_valid(y_valid),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mpick(input logic [3:0] r, input int base);
        for (int i = 0; i < 4; i++) begin
            if (r[(base + i) % 4]) return (base + i) % 4;
        end
        return -1;
    endfunction

    // Model advances on each rising edge using the inputs present at that edge.
    initial begin
        logic [3:0] others;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_owner = -1;
                m_ptr   = 0;
                m_hold  = 0;
                m_sel   = 0;
                m_valid = 1;
            end else if (m_valid) begin
                if (m_owner < 0) begin
                    if (req != 4'b0000) begin
                        m_owner = mpick(req, m_ptr);
                        m_sel   = m_owner;
                        m_hold  = 1;
                    end
                end else begin
                    others = req;
                    others[m_owner] = 1'b0;
                    if (!req[m_owner] || (m_hold == MAX_HOLD && others != 4'b0000)) begin
                        m_ptr = (m_owner + 1) % 4;
                        if (others != 4'b0000) begin
                            m_owner = mpick(others, m_ptr);
                            m_sel   = m_owner;
                            m_hold  = 1;
                        end else begin
                            m_owner = -1;
                        end
                    end else if (m_hold < MAX_HOLD) begin
                        m_hold = m_hold + 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        logic [8:0] act, exp;
        logic [3:0] eg;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                eg  = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
                exp = {eg, 2'(m_sel), (m_owner >= 0) & data[m_sel], |eg, |eg};
                act = {gnt, s1, s0, y, y_valid, busy};
                n_vec++;
                if (act !== exp) begin
                    n_bad++;
                    $display("FAIL model t=%0t: got {gnt,s1s0,y,yv,busy}=%b expected %b (req=%b I=%b)",
                             $time, act, exp, req, data);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic check_lit(input string name, input logic [3:0] eg, input logic [1:0] es, input logic ey);
        logic [8:0] act, exp;
        act = {gnt, s1, s0, y, y_valid, busy};
        exp = {eg, es, ey, |eg, |eg};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {gnt,s1s0,y,yv,busy}=%b expected %b", name, act, exp);
        end
    endtask

    initial begin
        int exp_seq[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        logic [3:0] r;

        // Reset with all requests raised, then idle.
        rst_n = 1'b0; req = 4'b1111; data = 4'b1111;
        cyc(); cyc();
        check_lit("reset", 4'b0000, 2'b00, 1'b0);
        rst_n = 1'b1; req = 4'b0000;
        cyc(); check_lit("idle0", 4'b0000, 2'b00, 1'b0);
        cyc(); check_lit("idle1", 4'b0000, 2'b00, 1'b0);

        // Single requester and data path.
        req = 4'b0100; data = 4'b0100;
        cyc(); check_lit("single_grant", 4'b0100, 2'b10, 1'b1);
        data = 4'b0000;
        cyc(); check_lit("single_y0", 4'b0100, 2'b10, 1'b0);
        data = 4'b0100;
        cyc(); check_lit("single_y1", 4'b0100, 2'b10, 1'b1);
        req = 4'b0000;
        cyc(); check_lit("single_drop", 4'b0000, 2'b10, 1'b0);

        // Round-robin: each owner drops after one cycle and re-raises.
        rst_n = 1'b0; data = 4'b0000;
        cyc();
        rst_n = 1'b1; req = 4'b1111;
        cyc(); check_lit("rr0", 4'b0001, 2'b00, 1'b0);
        req = 4'b1110;
        cyc(); check_lit("rr1", 4'b0010, 2'b01, 1'b0);
        req = 4'b1101;
        cyc(); check_lit("rr2", 4'b0100, 2'b10, 1'b0);
        req = 4'b1011;
        cyc(); check_lit("rr3", 4'b1000, 2'b11, 1'b0);
        req = 4'b0111;
        cyc(); check_lit("rr4", 4'b0001, 2'b00, 1'b0);

        // Hold limit with two contenders, then a lone requester.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; req = 4'b0011;
        for (int i = 0; i < 9; i++) begin
            cyc();
            check_lit("hold_seq", 4'b0001 << exp_seq[i], 2'(exp_seq[i]), 1'b0);
        end
        req = 4'b0001;
        for (int i = 0; i < 22; i++) begin
            cyc();
            check_lit("lone_hold", 4'b0001, 2'b00, 1'b0);
        end

        // Wrap-around of the pointer after requester 3.
        rst_n = 1'b0; req = 4'b0000;
        cyc();
        rst_n = 1'b1; req = 4'b1000;
        cyc(); check_lit("wrap_g3", 4'b1000, 2'b11, 1'b0);
        req = 4'b0000;
        cyc(); check_lit("wrap_rel3", 4'b0000, 2'b11, 1'b0);
        req = 4'b1001;
        cyc(); check_lit("wrap_g0", 4'b0001, 2'b00, 1'b0);
        req = 4'b0110;
        cyc(); check_lit("wrap_g1", 4'b0010, 2'b01, 1'b0);

        // Reset in the middle of a grant.
        rst_n = 1'b0; req = 4'b0000;
        cyc();
        rst_n = 1'b1; req = 4'b1000;
        cyc(); check_lit("mid_g3", 4'b1000, 2'b11, 1'b0);
        rst_n = 1'b0;
        cyc(); check_lit("mid_reset", 4'b0000, 2'b00, 1'b0);
        rst_n = 1'b1; req = 4'b1100;
        cyc(); check_lit("mid_after", 4'b0100, 2'b10, 1'b0);

        // Randomized traffic; the per-cycle model compare does the checking.
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 4) r = 4'($urandom_range(0, 15));
            req   = r;
            data  = 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 149) != 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
